// File: rtl/mtm_alu_pkg.sv
// -----------------------------------------------------------------------------
// mtm_alu_pkg
// Shared definitions for the ALU datapath serial links: frame layout
// constants, error codes, flag bit positions and the 3-bit response CRC.
// The CRC and error-byte helpers live here so the serializer, the ALU model
// and the bench all build frames from the same definitions.
// -----------------------------------------------------------------------------
package mtm_alu_pkg;

    // Serial frame: start(0), type, D7..D0, stop(1)
    localparam int unsigned FRAME_BITS = 11;
    localparam logic        TYPE_DATA  = 1'b0;
    localparam logic        TYPE_CTL   = 1'b1;

    // Error codes carried in an error response
    localparam logic [5:0] ERR_DATA = 6'b100100;
    localparam logic [5:0] ERR_CRC  = 6'b010010;
    localparam logic [5:0] ERR_OP   = 6'b001001;

    // Bit positions inside flags[3:0] = {carry, overflow, zero, negative}
    localparam int unsigned FLAG_CARRY    = 3;
    localparam int unsigned FLAG_OVERFLOW = 2;
    localparam int unsigned FLAG_ZERO     = 1;
    localparam int unsigned FLAG_NEGATIVE = 0;

    // Index of the final frame of each response type
    localparam logic [2:0] RESULT_LAST_FRAME = 3'd4;
    localparam logic [2:0] ERROR_LAST_FRAME  = 3'd0;

    // CRC x^3+x+1, init 000, over {C, 1'b0, flags}, MSB enters first.
    function automatic logic [2:0] crc3(input logic [36:0] data);
        logic [2:0] crc;
        logic       fb;
        crc = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb  = crc[2] ^ data[i];
            crc = {crc[1], crc[0] ^ fb, fb};
        end
        return crc;
    endfunction

    // Error control byte: marker 1, code, then a bit making the byte even parity.
    function automatic logic [7:0] err_byte(input logic [5:0] code);
        return {1'b1, code, ^{1'b1, code}};
    endfunction

endpackage

// File: rtl/mtm_alu_serializer_if.sv
// -----------------------------------------------------------------------------
// mtm_alu_serializer_if
// Request/response bundle between the ALU core (master) and the serializer
// (slave).
//   in_valid  master->slave  request on C/flags/err/err_flags is valid
//   in_ready  slave->master  serializer idle, request accepted this edge
//   C         master->slave  32-bit result word
//   flags     master->slave  {carry, overflow, zero, negative}
//   err       master->slave  send an error frame instead of a result
//   err_flags master->slave  6-bit error code
//   sout      slave->master  serial output line, idles high
//   busy      slave->master  response in flight
// -----------------------------------------------------------------------------
interface mtm_alu_serializer_if;
    import mtm_alu_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] C;
    logic [3:0]  flags;
    logic        err;
    logic [5:0]  err_flags;
    logic        sout;
    logic        busy;

    modport master (
        output in_valid, C, flags, err, err_flags,
        input  in_ready, sout, busy
    );

    modport slave (
        input  in_valid, C, flags, err, err_flags,
        output in_ready, sout, busy
    );

endinterface

// File: rtl/mtm_alu_frame_tx.sv
// -----------------------------------------------------------------------------
// mtm_alu_frame_tx
// Shifts one 11-bit frame {0, type, D7..D0, 1} onto sout, each bit held for
// CLKS_PER_BIT clocks (legal 1..16).
//   clk, rst   clock, async active-high reset
//   start      begin a frame (honoured in IDLE, and in the last STOP cycle
//              so frames can run back to back)
//   frm_type   frame type bit, sampled at the end of the start bit
//   frm_byte   payload byte,   sampled at the end of the start bit
//   sout       registered serial line, 1 when idle
//   idle       no frame in progress
//   done       last clock of the stop bit
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | line high, waiting for start
//   ST_START  | start bit (0) on the line
//   ST_TYPE   | type bit on the line
//   ST_DATA   | D[bit_cnt] on the line, bit_cnt 7..0
//   ST_STOP   | stop bit (1) on the line
// -----------------------------------------------------------------------------
module mtm_alu_frame_tx
    import mtm_alu_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       frm_type,
    input  logic [7:0] frm_byte,
    output logic       sout,
    output logic       idle,
    output logic       done
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_TYPE  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    localparam logic [3:0] CNT_LAST = 4'(CLKS_PER_BIT - 1);

    logic [2:0] state;
    logic [3:0] clk_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] byte_r;
    logic       tick;

    assign tick = (clk_cnt == CNT_LAST);
    assign idle = (state == ST_IDLE);
    assign done = (state == ST_STOP) && tick;

    // sout is assigned the value of the state being entered, so the line
    // always changes on the same edge as the state and stays glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            byte_r  <= '0;
            sout    <= 1'b1;
        end else begin
            if (state != ST_IDLE) begin
                clk_cnt <= tick ? 4'd0 : clk_cnt + 4'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_START;
                        clk_cnt <= '0;
                        sout    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        // Payload is latched here, one bit-time after start,
                        // so the sequencer can present it from its captured
                        // registers rather than from the live inputs.
                        state  <= ST_TYPE;
                        byte_r <= frm_byte;
                        sout   <= frm_type;
                    end
                end
                ST_TYPE: begin
                    if (tick) begin
                        state   <= ST_DATA;
                        bit_cnt <= 3'd7;
                        sout    <= byte_r[7];
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt == 3'd0) begin
                            state <= ST_STOP;
                            sout  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt - 3'd1;
                            sout    <= byte_r[bit_cnt - 3'd1];
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (start) begin
                            state <= ST_START;
                            sout  <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            sout  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    sout  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/mtm_alu_serializer.sv
// -----------------------------------------------------------------------------
// mtm_alu_serializer
// Output stage of the ALU datapath. Accepts one result (C + flags) or one
// error report and sends it on sout using the 11-bit frame format.
//   clk, rst   clock, async active-high reset
//   bus        mtm_alu_serializer_if.slave:
//                in_valid/in_ready handshake, C, flags, err, err_flags in;
//                sout, busy out
// Result response: four data frames C[31:24]..C[7:0], then control frame
// {0, flags, crc}. Error response: one control frame {1, code, parity}.
// CLKS_PER_BIT (1..16) sets the clocks per serial bit.
// -----------------------------------------------------------------------------
module mtm_alu_serializer
    import mtm_alu_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mtm_alu_serializer_if.slave  bus
);

    logic [31:0] c_r;
    logic [3:0]  flags_r;
    logic        err_r;
    logic [5:0]  err_flags_r;
    logic [2:0]  byte_cnt;

    logic        accept;
    logic        more;
    logic [2:0]  last_frame;
    logic [2:0]  crc;
    logic        tx_start;
    logic        tx_type;
    logic [7:0]  tx_byte;
    logic        tx_sout;
    logic        tx_idle;
    logic        tx_done;

    assign accept     = bus.in_valid && bus.in_ready;
    assign last_frame = err_r ? ERROR_LAST_FRAME : RESULT_LAST_FRAME;
    assign more       = (byte_cnt < last_frame);
    assign tx_start   = accept || (tx_done && more);
    assign crc        = crc3({c_r, 1'b0, flags_r});

    assign bus.in_ready = tx_idle;
    assign bus.busy     = !tx_idle;
    assign bus.sout     = tx_sout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_r         <= '0;
            flags_r     <= '0;
            err_r       <= 1'b0;
            err_flags_r <= '0;
            byte_cnt    <= '0;
        end else if (accept) begin
            c_r         <= bus.C;
            flags_r     <= bus.flags;
            err_r       <= bus.err;
            err_flags_r <= bus.err_flags;
            byte_cnt    <= '0;
        end else if (tx_done) begin
            byte_cnt <= more ? byte_cnt + 3'd1 : 3'd0;
        end
    end

    // Payload for the frame in flight, selected by byte_cnt; err wins over C/flags.
    always_comb begin
        tx_type = TYPE_DATA;
        tx_byte = c_r[31:24];
        if (err_r) begin
            tx_type = TYPE_CTL;
            tx_byte = err_byte(err_flags_r);
        end else begin
            case (byte_cnt)
                3'd0:    tx_byte = c_r[31:24];
                3'd1:    tx_byte = c_r[23:16];
                3'd2:    tx_byte = c_r[15:8];
                3'd3:    tx_byte = c_r[7:0];
                default: begin
                    tx_type = TYPE_CTL;
                    tx_byte = {1'b0, flags_r, crc};
                end
            endcase
        end
    end

    mtm_alu_frame_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_frame_tx (
        .clk      (clk),
        .rst      (rst),
        .start    (tx_start),
        .frm_type (tx_type),
        .frm_byte (tx_byte),
        .sout     (tx_sout),
        .idle     (tx_idle),
        .done     (tx_done)
    );

endmodule

// File: tb/tb_mtm_alu_serializer.sv
module tb_mtm_alu_serializer;
    import mtm_alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;

    always #5 clk = ~clk;

    mtm_alu_serializer_if if1();
    mtm_alu_serializer_if if3();

    mtm_alu_serializer #(.CLKS_PER_BIT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    mtm_alu_serializer #(.CLKS_PER_BIT(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

    wire m_sout  = sel ? if3.sout     : if1.sout;
    wire m_busy  = sel ? if3.busy     : if1.busy;
    wire m_ready = sel ? if3.in_ready : if1.in_ready;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [164:0] obs, input logic [164:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference CRC: remainder of (data * x^3) divided by x^3+x+1 over GF(2).
    function automatic logic [2:0] ref_crc(input logic [36:0] d);
        logic [39:0] v;
        v = {d, 3'b000};
        for (int i = 39; i >= 3; i--)
            if (v[i]) v[i -: 4] = v[i -: 4] ^ 4'b1011;
        return v[2:0];
    endfunction

    function automatic logic [10:0] ref_frame(input logic t, input logic [7:0] b);
        return {1'b0, t, b, 1'b1};
    endfunction

    task automatic ref_stream(input logic [31:0] c, input logic [3:0] f, input logic e,
                              input logic [5:0] ef, output logic [54:0] bits, output int nb);
        logic [7:0] eb;
        if (e) begin
            eb   = {1'b1, ef, 1'($countones({1'b1, ef}) % 2)};
            bits = {44'b0, ref_frame(1'b1, eb)};
            nb   = 11;
        end else begin
            bits = {ref_frame(1'b0, c[31:24]), ref_frame(1'b0, c[23:16]),
                    ref_frame(1'b0, c[15:8]),  ref_frame(1'b0, c[7:0]),
                    ref_frame(1'b1, {1'b0, f, ref_crc({c, 1'b0, f})})};
            nb   = 55;
        end
    endtask

    task automatic drive(input bit s, input logic v, input logic [31:0] c, input logic [3:0] f,
                         input logic e, input logic [5:0] ef);
        if (s) begin
            if3.in_valid = v; if3.C = c; if3.flags = f; if3.err = e; if3.err_flags = ef;
        end else begin
            if1.in_valid = v; if1.C = c; if1.flags = f; if1.err = e; if1.err_flags = ef;
        end
    endtask

    task automatic set_valid(input bit s, input logic v);
        if (s) if3.in_valid = v;
        else   if1.in_valid = v;
    endtask

    task automatic scramble(input bit s);
        drive(s, 1'b0, $urandom, 4'($urandom), 1'($urandom), 6'($urandom));
    endtask

    task automatic run_txn(input bit s, input logic [31:0] c, input logic [3:0] f, input logic e,
                           input logic [5:0] ef, input bit extra, input string tag);
        logic [54:0]  bits;
        logic [164:0] expv;
        logic [164:0] obsv;
        int nb, cpb, busy_cyc, quiet_bad;
        sel = s;
        cpb = s ? 3 : 1;
        ref_stream(c, f, e, ef, bits, nb);
        expv = '0;
        for (int k = nb - 1; k >= 0; k--)
            for (int r = 0; r < cpb; r++) expv = {expv[163:0], bits[k]};
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_ready) break;
        end
        check({tag, "_ready_before"}, 165'(m_ready), 165'd1);
        drive(s, 1'b1, c, f, e, ef);
        @(posedge clk); #1;
        scramble(s);
        obsv = '0;
        busy_cyc = 0;
        for (int i = 0; i < nb * cpb; i++) begin
            @(negedge clk);
            obsv = {obsv[163:0], m_sout};
            busy_cyc += int'(m_busy);
            if (extra && i == 5) set_valid(s, 1'b1);
            if (extra && i == 6) set_valid(s, 1'b0);
        end
        check({tag, "_sout"}, obsv, expv);
        check({tag, "_busy_len"}, 165'(busy_cyc), 165'(nb * cpb));
        @(negedge clk);
        check({tag, "_idle_after"}, 165'({m_ready, m_busy, m_sout}), 165'(3'b101));
        if (extra) begin
            quiet_bad = 0;
            for (int i = 0; i < 15; i++) begin
                @(negedge clk);
                if (m_busy || !m_sout) quiet_bad++;
            end
            check({tag, "_no_queued_req"}, 165'(quiet_bad), 165'd0);
        end
    endtask

    initial begin
        logic [31:0] rc;
        logic [3:0]  rf;
        logic [5:0]  ref6;
        int quiet_bad;

        drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_dut1", 165'({if1.in_ready, if1.busy, if1.sout}), 165'(3'b101));
        check("reset_dut3", 165'({if3.in_ready, if3.busy, if3.sout}), 165'(3'b101));
        rst = 1'b0;
        @(negedge clk);

        run_txn(1'b0, 32'h0, 4'b0000, 1'b0, 6'h0, 1'b0, "all_zero");
        run_txn(1'b0, 32'h0, 4'b0001, 1'b0, 6'h0, 1'b0, "crc_011");
        check("ref_crc_0001", 165'(ref_crc({32'h0, 1'b0, 4'b0001})), 165'(3'b011));
        run_txn(1'b0, 32'h12345678, 4'b0000, 1'b0, 6'h0, 1'b0, "c_12345678");
        check("pkg_crc_12345678", 165'(crc3({32'h12345678, 5'b0})),
              165'(ref_crc({32'h12345678, 5'b0})));
        run_txn(1'b0, $urandom, 4'($urandom), 1'b1, ERR_DATA, 1'b0, "err_data");
        run_txn(1'b0, $urandom, 4'($urandom), 1'b0, 6'h0, 1'b1, "busy_pulse");

        // Abort a result mid-stream with an extra request pending.
        sel = 1'b0;
        rc = $urandom;
        @(negedge clk);
        drive(1'b0, 1'b1, rc, 4'($urandom), 1'b0, 6'h0);
        @(posedge clk); #1;
        scramble(1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 10) set_valid(1'b0, 1'b1);
            if (i == 11) set_valid(1'b0, 1'b0);
        end
        check("mid_frame_busy", 165'(m_busy), 165'd1);
        #2 rst = 1'b1;
        #1 check("rst_async_outputs", 165'({m_ready, m_busy, m_sout}), 165'(3'b101));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        quiet_bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (m_busy || !m_sout || !m_ready) quiet_bad++;
        end
        check("post_rst_quiet", 165'(quiet_bad), 165'd0);
        run_txn(1'b0, $urandom, 4'($urandom), 1'b0, 6'h0, 1'b0, "post_rst_fresh");

        run_txn(1'b1, $urandom, 4'($urandom), 1'b1, ERR_OP, 1'b0, "cpb3_err_op");
        run_txn(1'b1, $urandom, 4'($urandom), 1'b0, 6'h0, 1'b0, "cpb3_result");
        run_txn(1'b1, $urandom, 4'($urandom), 1'b1, ERR_CRC, 1'b1, "cpb3_err_crc");

        for (int n = 0; n < 12; n++) begin
            rc   = $urandom;
            rf   = 4'($urandom);
            ref6 = 6'($urandom);
            run_txn(1'b0, rc, rf, ($urandom_range(0, 3) == 0), ref6, 1'b0, "rand");
            check("rand_pkg_crc", 165'(crc3({rc, 1'b0, rf})), 165'(ref_crc({rc, 1'b0, rf})));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
